ddr_frame_writer: RTL and testbench
===================================

Name: ddr_frame_writer

Overview:
Capture-side counterpart of the DDR frame readout path. Accepts an 8-bit pixel stream from the image capture front end and packs it into 64-bit words. Stages the words in a small local FIFO and writes them to DDR through an MCB-style write port (data FIFO plus command FIFO) in fixed bursts, starting at a host-supplied base byte address. Reports completion and byte count so the host can start readout of the same region.

Parameters:
BURST_LEN, 32, 64-bit words per full write command (1..64)
STAGE_DEPTH, 64, staging FIFO depth in 64-bit words (power of 2, >= 2*BURST_LEN)
STAGE_AW, 6, log2(STAGE_DEPTH)

Ports:
clk  in  1  system/MCB port clock
reset_clk  in  1  asynchronous, active-high reset
capture_arm  in  1  pulse: arm for next frame (ignored while capture_busy)
capture_addr  in  30  DDR base byte address, sampled on accepted arm; must be 8-byte aligned
pix_frame_start  in  1  first pixel of frame marker, qualified by pix_valid
pix_valid  in  1  pixel strobe
pix_data  in  8  pixel byte
pix_frame_end  in  1  last pixel of frame marker, qualified by pix_valid
capture_busy  out  1  high from accepted arm until capture_done
capture_done  out  1  one-cycle pulse after last command is issued
capture_count  out  24  bytes captured in the frame; valid from capture_done, held until next arm
capture_overflow  out  1  sticky: staging FIFO full when a word was dropped; cleared on arm
mem_wr_en  out  1  MCB write-data strobe
mem_wr_data  out  64  MCB write data
mem_wr_mask  out  8  byte mask, 1 = byte not written
mem_wr_full  in  1  MCB write FIFO full
mem_cmd_en  out  1  MCB command strobe
mem_cmd_instr  out  3  constant 3'b000 (write)
mem_cmd_byte_addr  out  30  command byte address
mem_cmd_burst_len  out  6  words in burst minus 1
mem_cmd_full  in  1  MCB command FIFO full

Behaviour:
- Reset: all outputs 0, state IDLE, staging FIFO empty, address/counters 0.
- Packer: active only between the frame-start pixel and the frame-end pixel, inclusive.
  - Pixel k of each 8-byte group goes to bits [8k+7:8k]; the first pixel lands in [7:0].
  - Eighth byte pushes the word into staging 1 cycle later.
  - Start and end markers on the same pixel give a 1-byte frame.
- Frame end with a partial word: the word is zero-padded and pushed with mask bits set for the unfilled bytes.
- Staging FIFO full at push: the word is dropped, capture_overflow is set, and capture_count still counts its bytes.
- FSM states:
  - IDLE: on capture_arm, latch address, clear count/overflow, set busy, go to ARMED.
  - ARMED: wait for pix_valid&pix_frame_start, then go to FILL; pixels before the start marker are ignored.
  - FILL: if staged >= BURST_LEN, go to DATA with n=BURST_LEN. Else if frame ended and packer flushed: go to DATA with n=staged if staged>0, otherwise go to DONE.
  - DATA: pop a word and assert mem_wr_en when !mem_wr_full; mem_wr_en is never high while mem_wr_full. After n words, go to CMD.
  - CMD: hold mem_cmd_en pending until !mem_cmd_full; pulse it for exactly 1 cycle with addr and burst_len=n-1. Then addr += 8*n (mod 2^30) and go to FILL.
  - DONE: capture_done pulse, busy low, go to IDLE.
- mem_cmd_en is asserted no earlier than the cycle after the burst's last mem_wr_en; data always precedes its command.
- The packer keeps accepting pixels during DATA and CMD. There is no pixel backpressure; only overflow signals loss.
- capture_count: 24-bit byte counter, saturates at 2^24-1.
- Arm pulses while busy are ignored. A start marker received outside ARMED is ignored.
- Reset mid-frame: the block returns to IDLE immediately, with no command for partially written data. Before re-arming, the host resets the MCB port.

Decomposition:
- Shared package (ddr_frame_pkg): MCB_INSTR_WRITE=3'b000, MCB_INSTR_READ=3'b001, BYTES_PER_WORD=8, FSM state encoding.
- Sub-module: frame_stage_fifo (synchronous FWFT FIFO, 64-bit, STAGE_DEPTH, with count output). The FSM and packer stay in the top module.

Test Plan:
- Arm at 0x0001000, then a 256-byte frame -> 32 mem_wr_en, all mask 8'h00; one command, addr 0x0001000, burst_len 31; capture_done with capture_count=256.
- A 300-byte frame at 0x0000000 -> first burst of 32 words at 0x0000000, then a second burst of 6 words (burst_len 5) at 0x0000100. Last word has mask 8'hF0 and upper bytes zero; capture_count=300.
- Hold mem_wr_full high 10 cycles mid-burst -> no mem_wr_en while full, no word lost or duplicated; data sequence intact.
- Hold mem_cmd_full for 5 cycles in CMD -> mem_cmd_en is a single pulse after release; the next burst address advances by 256.
- Stall mem_wr_full for a long frame -> capture_overflow=1, capture_count still equals pixel count. A new arm clears overflow.
- Assert reset_clk mid-frame, then arm again and send a 64-byte frame -> outputs zero during reset; a clean 8-word burst at the new address; capture_count=64.

Source files
------------

// File: rtl/ddr_frame_pkg.sv
// Shared definitions for the DDR frame capture path: MCB opcodes, word geometry, FSM encoding.
package ddr_frame_pkg;

  localparam logic [2:0]  MCB_INSTR_WRITE = 3'b000;
  localparam logic [2:0]  MCB_INSTR_READ  = 3'b001;
  localparam int unsigned BYTES_PER_WORD  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StFill,
    StData,
    StCmd,
    StDone
  } state_e;

  // Byte mask for a word whose last filled byte is last_idx (1 = byte not written).
  function automatic logic [7:0] pad_mask(input logic [2:0] last_idx);
    logic [7:0] m;
    m = 8'hFE;
    return m << last_idx;
  endfunction

endpackage

// File: rtl/frame_stage_fifo.sv
// Synchronous first-word-fall-through staging FIFO with occupancy count.
module frame_stage_fifo #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Aw    = 6,
  parameter int unsigned Width = 72
) (
  input  logic             clk,
  input  logic             reset_clk,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Aw:0]      count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [Aw:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == (Aw+1)'(Depth));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + Aw'(do_wr);
    rd_ptr_d = rd_ptr_q + Aw'(do_rd);
    count_d  = count_q + (Aw+1)'(do_wr) - (Aw+1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge reset_clk) begin
    if (reset_clk) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ddr_frame_writer.sv
// Packs an 8-bit pixel stream into 64-bit words, stages them and writes them to DDR in
// fixed bursts through an MCB-style write port.
module ddr_frame_writer
  import ddr_frame_pkg::*;
#(
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned STAGE_DEPTH = 64,
  parameter int unsigned STAGE_AW    = 6
) (
  input  logic        clk,
  input  logic        reset_clk,
  input  logic        capture_arm,
  input  logic [29:0] capture_addr,
  input  logic        pix_frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic        pix_frame_end,
  output logic        capture_busy,
  output logic        capture_done,
  output logic [23:0] capture_count,
  output logic        capture_overflow,
  output logic        mem_wr_en,
  output logic [63:0] mem_wr_data,
  output logic [7:0]  mem_wr_mask,
  input  logic        mem_wr_full,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [29:0] mem_cmd_byte_addr,
  output logic [5:0]  mem_cmd_burst_len,
  input  logic        mem_cmd_full
);

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [23:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [6:0]  n_q, n_d;
  logic [6:0]  wcnt_q, wcnt_d;
  logic        in_frame_q, in_frame_d;
  logic [63:0] pack_word_q, pack_word_d;
  logic [2:0]  pack_idx_q, pack_idx_d;
  logic        push_q, push_d;
  logic [71:0] push_data_q, push_data_d;
  logic        last_push_q, last_push_d;
  logic        flushed_q, flushed_d;

  logic              arm_take, pix_take, pop;
  logic [63:0]       word_ins;
  logic [71:0]       stage_rd_data;
  logic              stage_full, stage_empty;
  logic [STAGE_AW:0] stage_count;

  frame_stage_fifo #(
    .Depth (STAGE_DEPTH),
    .Aw    (STAGE_AW),
    .Width (72)
  ) u_stage (
    .clk       (clk),
    .reset_clk (reset_clk),
    .wr_en_i   (push_q),
    .wr_data_i (push_data_q),
    .rd_en_i   (pop),
    .rd_data_o (stage_rd_data),
    .full_o    (stage_full),
    .empty_o   (stage_empty),
    .count_o   (stage_count)
  );

  assign arm_take = (state_q == StIdle) && capture_arm;
  // A start marker only opens a frame while armed; inside a frame it is an ordinary pixel.
  assign pix_take = pix_valid && (in_frame_q || ((state_q == StArmed) && pix_frame_start));

  always_comb begin
    word_ins = pack_word_q;
    word_ins[{pack_idx_q, 3'b000} +: 8] = pix_data;
  end

  // Packer, byte counter and sticky overflow.
  always_comb begin
    count_d     = count_q;
    ovf_d       = ovf_q;
    in_frame_d  = in_frame_q;
    pack_word_d = pack_word_q;
    pack_idx_d  = pack_idx_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    last_push_d = 1'b0;
    flushed_d   = flushed_q;
    if (arm_take) begin
      count_d   = '0;
      ovf_d     = 1'b0;
      flushed_d = 1'b0;
    end
    if (pix_take) begin
      if (count_q != '1) count_d = count_q + 24'd1;
      in_frame_d = !pix_frame_end;
      if (pack_idx_q == 3'd7 || pix_frame_end) begin
        push_d      = 1'b1;
        push_data_d = {pad_mask(pack_idx_q), word_ins};
        last_push_d = pix_frame_end;
        pack_word_d = '0;
        pack_idx_d  = '0;
      end else begin
        pack_word_d = word_ins;
        pack_idx_d  = pack_idx_q + 3'd1;
      end
    end
    if (push_q && stage_full) ovf_d = 1'b1;
    // Flushed becomes visible once the final word is reflected in the stage count.
    if (push_q && last_push_q) flushed_d = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    n_d          = n_q;
    wcnt_d       = wcnt_q;
    pop          = 1'b0;
    mem_wr_en    = 1'b0;
    mem_cmd_en   = 1'b0;
    capture_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (capture_arm) begin
          addr_d  = capture_addr;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (pix_valid && pix_frame_start) state_d = StFill;
      end
      StFill: begin
        wcnt_d = '0;
        if (stage_count >= (STAGE_AW+1)'(BURST_LEN)) begin
          n_d     = 7'(BURST_LEN);
          state_d = StData;
        end else if (flushed_q) begin
          if (stage_count != '0) begin
            n_d     = 7'(stage_count);
            state_d = StData;
          end else begin
            state_d = StDone;
          end
        end
      end
      StData: begin
        if (!mem_wr_full && !stage_empty) begin
          mem_wr_en = 1'b1;
          pop       = 1'b1;
          wcnt_d    = wcnt_q + 7'd1;
          if (wcnt_q == n_q - 7'd1) state_d = StCmd;
        end
      end
      StCmd: begin
        if (!mem_cmd_full) begin
          mem_cmd_en = 1'b1;
          addr_d     = addr_q + 30'(n_q) * 30'(BYTES_PER_WORD);
          state_d    = StFill;
        end
      end
      StDone: begin
        capture_done = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign capture_busy      = (state_q == StArmed) || (state_q == StFill) ||
                             (state_q == StData)  || (state_q == StCmd);
  assign capture_count     = count_q;
  assign capture_overflow  = ovf_q;
  assign mem_wr_data       = mem_wr_en ? stage_rd_data[63:0] : '0;
  assign mem_wr_mask       = mem_wr_en ? stage_rd_data[71:64] : '0;
  assign mem_cmd_instr     = MCB_INSTR_WRITE;
  assign mem_cmd_byte_addr = mem_cmd_en ? addr_q : '0;
  assign mem_cmd_burst_len = mem_cmd_en ? 6'(n_q - 7'd1) : '0;

  always_ff @(posedge clk or posedge reset_clk) begin
    if (reset_clk) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      n_q         <= '0;
      wcnt_q      <= '0;
      in_frame_q  <= 1'b0;
      pack_word_q <= '0;
      pack_idx_q  <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      last_push_q <= 1'b0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      n_q         <= n_d;
      wcnt_q      <= wcnt_d;
      in_frame_q  <= in_frame_d;
      pack_word_q <= pack_word_d;
      pack_idx_q  <= pack_idx_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      last_push_q <= last_push_d;
      flushed_q   <= flushed_d;
    end
  end

endmodule

// File: tb/tb_ddr_frame_writer.sv
// Self-checking bench for ddr_frame_writer: table of frame scenarios plus overflow and reset cases.
module tb_ddr_frame_writer;

  logic        clk = 1'b0;
  logic        reset_clk;
  logic        capture_arm;
  logic [29:0] capture_addr;
  logic        pix_frame_start, pix_valid, pix_frame_end;
  logic [7:0]  pix_data;
  logic        capture_busy, capture_done, capture_overflow;
  logic [23:0] capture_count;
  logic        mem_wr_en, mem_wr_full, mem_cmd_en, mem_cmd_full;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_mask;
  logic [2:0]  mem_cmd_instr;
  logic [29:0] mem_cmd_byte_addr;
  logic [5:0]  mem_cmd_burst_len;

  always #5 clk = ~clk;

  ddr_frame_writer dut (
    .clk               (clk),
    .reset_clk         (reset_clk),
    .capture_arm       (capture_arm),
    .capture_addr      (capture_addr),
    .pix_frame_start   (pix_frame_start),
    .pix_valid         (pix_valid),
    .pix_data          (pix_data),
    .pix_frame_end     (pix_frame_end),
    .capture_busy      (capture_busy),
    .capture_done      (capture_done),
    .capture_count     (capture_count),
    .capture_overflow  (capture_overflow),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_data       (mem_wr_data),
    .mem_wr_mask       (mem_wr_mask),
    .mem_wr_full       (mem_wr_full),
    .mem_cmd_en        (mem_cmd_en),
    .mem_cmd_instr     (mem_cmd_instr),
    .mem_cmd_byte_addr (mem_cmd_byte_addr),
    .mem_cmd_burst_len (mem_cmd_burst_len),
    .mem_cmd_full      (mem_cmd_full)
  );

  typedef struct {
    logic [29:0] addr;
    int          nbytes;
    bit          stall_wr;
    bit          stall_cmd;
    bit          rearm;
    int          exp_words;
    int          exp_cmds;
    logic [29:0] exp_last_addr;
    logic [5:0]  exp_last_bl;
    logic [7:0]  exp_last_mask;
    int          exp_count;
  } frame_t;

  logic [63:0] wr_data_q[$];
  logic [7:0]  wr_mask_q[$];
  logic [29:0] cmd_addr_q[$];
  logic [5:0]  cmd_bl_q[$];
  int          viol = 0;
  int          since_cmd = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Port monitor: records writes/commands and counts handshake/ordering violations.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_clk) begin
        if (mem_wr_en && mem_wr_full) viol++;
        if (mem_cmd_en && mem_cmd_full) viol++;
        if (mem_cmd_en) begin
          if (mem_wr_en || since_cmd != int'(mem_cmd_burst_len) + 1 || mem_cmd_instr != 3'b000)
            viol++;
          cmd_addr_q.push_back(mem_cmd_byte_addr);
          cmd_bl_q.push_back(mem_cmd_burst_len);
          since_cmd = 0;
        end
        if (mem_wr_en) begin
          wr_data_q.push_back(mem_wr_data);
          wr_mask_q.push_back(mem_wr_mask);
          since_cmd++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] pix(input int i, input int seed);
    return 8'(i * 13 + seed * 29 + 5);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [29:0] a);
    capture_arm  = 1'b1;
    capture_addr = a;
    tick();
    capture_arm  = 1'b0;
    capture_addr = '0;
  endtask

  task automatic send_pixels(input int n, input int seed, input bit rearm, input bit do_end);
    for (int i = 0; i < n; i++) begin
      pix_valid       = 1'b1;
      pix_data        = pix(i, seed);
      pix_frame_start = (i == 0) || (rearm && i == 60);
      pix_frame_end   = do_end && (i == n - 1);
      capture_arm     = rearm && (i == 50);
      capture_addr    = (rearm && i == 50) ? 30'h000BAD0 : 30'h0;
      tick();
    end
    pix_valid       = 1'b0;
    pix_data        = '0;
    pix_frame_start = 1'b0;
    pix_frame_end   = 1'b0;
    capture_arm     = 1'b0;
    capture_addr    = '0;
  endtask

  task automatic wait_words(input int target);
    for (int k = 0; k < 5000 && wr_data_q.size() < target; k++) tick();
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 5000 && !got; k++) begin
      @(negedge clk);
      if (capture_done) got = 1'b1;
    end
    check({tag, ".done"}, 64'(got), 64'd1);
  endtask

  task automatic run_frame(input frame_t f, input int seed, input string tag);
    int bw, bc, nw, nc, errs;
    logic [63:0] ew;
    logic [7:0]  em;
    bw = wr_data_q.size();
    bc = cmd_addr_q.size();
    arm(f.addr);
    check({tag, ".busy"}, 64'(capture_busy), 64'd1);
    check({tag, ".ovf_clr"}, 64'(capture_overflow), 64'd0);
    // Stray pixels (one with an end marker) before the start marker must be ignored.
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1; pix_data = 8'hEE; pix_frame_end = (i == 1);
      tick();
    end
    pix_valid = 1'b0; pix_frame_end = 1'b0;
    if (f.stall_cmd) mem_cmd_full = 1'b1;
    fork
      send_pixels(f.nbytes, seed, f.rearm, 1'b1);
      if (f.stall_wr) begin
        wait_words(bw + 10);
        mem_wr_full = 1'b1;
        repeat (10) tick();
        mem_wr_full = 1'b0;
      end
      if (f.stall_cmd) begin
        wait_words(bw + 32);
        repeat (5) tick();
        mem_cmd_full = 1'b0;
      end
    join
    wait_done(tag);
    check({tag, ".count"}, 64'(capture_count), 64'(f.exp_count));
    check({tag, ".ovf"}, 64'(capture_overflow), 64'd0);
    check({tag, ".busy_lo"}, 64'(capture_busy), 64'd0);
    tick();
    nw = wr_data_q.size() - bw;
    nc = cmd_addr_q.size() - bc;
    check({tag, ".words"}, 64'(nw), 64'(f.exp_words));
    errs = 0;
    for (int j = 0; j < nw && j < f.exp_words; j++) begin
      for (int b = 0; b < 8; b++) begin
        ew[8*b +: 8] = (8*j + b < f.nbytes) ? pix(8*j + b, seed) : 8'h00;
        em[b]        = (8*j + b >= f.nbytes);
      end
      if (wr_data_q[bw + j] !== ew || wr_mask_q[bw + j] !== em) errs++;
    end
    check({tag, ".data"}, 64'(errs), 64'd0);
    if (nw > 0) check({tag, ".last_mask"}, 64'(wr_mask_q[bw + nw - 1]), 64'(f.exp_last_mask));
    check({tag, ".cmds"}, 64'(nc), 64'(f.exp_cmds));
    if (nc > 0) begin
      check({tag, ".first_addr"}, 64'(cmd_addr_q[bc]), 64'(f.addr));
      check({tag, ".last_addr"}, 64'(cmd_addr_q[bc + nc - 1]), 64'(f.exp_last_addr));
      check({tag, ".last_bl"}, 64'(cmd_bl_q[bc + nc - 1]), 64'(f.exp_last_bl));
    end
  endtask

  frame_t vec[6];
  frame_t tail_a, tail_b;
  int     bw_ovf, bc_ovf;

  initial begin
    //          addr          bytes wr cmd re words cmds last_addr     bl  mask    count
    vec[0] = '{30'h0001000,  256,  0, 0, 0, 32,   1,   30'h0001000,  31, 8'h00,  256};
    vec[1] = '{30'h0000000,  300,  0, 0, 1, 38,   2,   30'h0000100,  5,  8'hF0,  300};
    vec[2] = '{30'h0002000,  256,  1, 0, 0, 32,   1,   30'h0002000,  31, 8'h00,  256};
    vec[3] = '{30'h0003000,  512,  0, 1, 0, 64,   2,   30'h0003100,  31, 8'h00,  512};
    vec[4] = '{30'h0000040,  1,    0, 0, 0, 1,    1,   30'h0000040,  0,  8'hFE,  1};
    vec[5] = '{30'h3FFFFF00, 260,  0, 0, 0, 33,   2,   30'h0000000,  0,  8'hF0,  260};
    tail_a = '{30'h0005800,  16,   0, 0, 0, 2,    1,   30'h0005800,  1,  8'h00,  16};
    tail_b = '{30'h0007000,  64,   0, 0, 0, 8,    1,   30'h0007000,  7,  8'h00,  64};

    reset_clk = 1'b1; capture_arm = 1'b0; capture_addr = '0;
    pix_frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_frame_end = 1'b0;
    mem_wr_full = 1'b0; mem_cmd_full = 1'b0;
    repeat (3) tick();
    check("reset.outs", {capture_busy, capture_done, capture_overflow, mem_wr_en, mem_cmd_en,
                         mem_cmd_instr, mem_wr_mask}, 64'd0);
    check("reset.count", 64'(capture_count), 64'd0);
    reset_clk = 1'b0;
    tick();

    for (int r = 0; r < 6; r++) run_frame(vec[r], r + 1, $sformatf("vec%0d", r));

    // Overflow: write port stalled for a 128-word frame; only 64 words fit in staging.
    bw_ovf = wr_data_q.size();
    bc_ovf = cmd_addr_q.size();
    arm(30'h0005000);
    mem_wr_full = 1'b1;
    send_pixels(1024, 7, 1'b0, 1'b1);
    repeat (3) tick();
    check("ovf.flag", 64'(capture_overflow), 64'd1);
    mem_wr_full = 1'b0;
    wait_done("ovf");
    check("ovf.count", 64'(capture_count), 64'd1024);
    check("ovf.sticky", 64'(capture_overflow), 64'd1);
    tick();
    check("ovf.words", 64'(wr_data_q.size() - bw_ovf), 64'd64);
    check("ovf.cmds", 64'(cmd_addr_q.size() - bc_ovf), 64'd2);
    run_frame(tail_a, 8, "post_ovf");

    // Reset mid-frame, then a clean frame at a new address.
    bc_ovf = cmd_addr_q.size();
    arm(30'h0006000);
    send_pixels(100, 9, 1'b0, 1'b0);
    reset_clk = 1'b1;
    tick();
    check("rst_mid.outs", {capture_busy, capture_done, capture_overflow, mem_wr_en, mem_cmd_en,
                           mem_cmd_byte_addr}, 64'd0);
    check("rst_mid.count", 64'(capture_count), 64'd0);
    repeat (2) tick();
    reset_clk = 1'b0;
    tick();
    check("rst_mid.no_cmd", 64'(cmd_addr_q.size() - bc_ovf), 64'd0);
    run_frame(tail_b, 10, "post_rst");

    check("protocol", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
